// File: rtl/pu_ifetch.sv
// Instruction prefetch unit: fetches bus words into a small buffer and hands out 16-bit halfwords.
// Latency: first instruction one cycle after its read completes (same cycle with PU_IFETCH_BYPASS_EN).
// Backpressure: stops issuing reads while the buffer is full; instr_rdy_i stalls the halfword stream.
//
// Optional feature macro: PU_IFETCH_BYPASS_EN (buffer-empty bypass of the returning read word).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   redir_i, redir_addr_i        redirect/flush with new halfword address
//   pi1_op_o/addr_o/data_o/sel_o bus request (read only, data_o tied to 0)
//   pi1_data_i, pi1_rdy_i        bus read data and completion
//   instr_o/addr_o/vld_o, instr_rdy_i  head halfword stream
//   empty_o                      buffer holds no words
module pu_ifetch #(
  parameter int ARCHBITSZ = 32,
  parameter int BUFSZ     = 4,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   redir_i,
  input  logic [ARCHBITSZ-2:0]   redir_addr_i,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  input  logic                   pi1_rdy_i,
  output logic [15:0]            instr_o,
  output logic [ARCHBITSZ-2:0]   instr_addr_o,
  output logic                   instr_vld_o,
  input  logic                   instr_rdy_i,
  output logic                   empty_o
);

  localparam int HPW    = ARCHBITSZ / 16;       // halfwords per bus word
  localparam int HWBITS = $clog2(HPW);
  localparam int PTRW   = $clog2(BUFSZ);
  localparam int CNTW   = PTRW + 1;
  localparam logic [CNTW-1:0]   FULL    = CNTW'(BUFSZ);
  localparam logic [HWBITS-1:0] LAST_HW = HWBITS'(HPW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   fetch_en_q;
  logic [ADDRBITSZ-1:0]   fetch_addr_q;   // address of the read on the bus / next to issue
  logic [ADDRBITSZ-1:0]   drain_addr_q;   // redirect target parked while a stale read drains
  logic [ARCHBITSZ-1:0]   mem_q [BUFSZ];
  logic [PTRW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0]        count_q, count_nxt;
  logic [HWBITS-1:0]      hd_off_q;       // next halfword to pop within the head word
  logic [ARCHBITSZ-2:0]   instr_addr_q;

  logic [ADDRBITSZ-1:0]   redir_word;
  logic [HWBITS-1:0]      redir_off;
  logic                   buf_empty, push, pop, free, bypass, vld;
  logic [ARCHBITSZ-1:0]   head_word;
  logic [15:0]            head_hw;

  assign redir_word = redir_addr_i[ARCHBITSZ-2:HWBITS];
  assign redir_off  = redir_addr_i[HWBITS-1:0];

  // A redirect in the same cycle wins over both push and pop.
  assign buf_empty = (count_q == '0);
  assign push      = (state_q == REQ) && pi1_rdy_i && !redir_i;

`ifdef PU_IFETCH_BYPASS_EN
  assign bypass = buf_empty && push;
`else
  assign bypass = 1'b0;
`endif

  assign head_word = bypass ? pi1_data_i : mem_q[rd_ptr_q];
  assign head_hw   = 16'(head_word >> {hd_off_q, 4'b0000});
  assign vld       = !rst_i && (!buf_empty || bypass);
  assign pop       = vld && instr_rdy_i && !redir_i;
  assign free      = pop && (hd_off_q == LAST_HW);
  // On a bypassed pop that frees the word, push and free cancel and both pointers advance together.
  assign count_nxt = count_q + CNTW'(push) - CNTW'(free);

  assign instr_vld_o  = vld;
  assign instr_o      = vld ? head_hw : 16'h0000;
  assign instr_addr_o = rst_i ? '0 : instr_addr_q;
  assign empty_o      = rst_i || buf_empty;
  assign pi1_data_o   = '0;

  always_comb begin
    state_d    = state_q;
    pi1_op_o   = 2'b00;
    pi1_addr_o = '0;
    pi1_sel_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (redir_i || (fetch_en_q && (count_q < FULL))) state_d = REQ;
      end
      REQ: begin
        if (redir_i)                                  state_d = pi1_rdy_i ? REQ : DRAIN;
        else if (pi1_rdy_i && !(count_nxt < FULL))    state_d = IDLE;
      end
      DRAIN: begin
        if (pi1_rdy_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // DRAIN keeps the stale read's address on the bus until it completes.
    if (!rst_i && (state_q != IDLE)) begin
      pi1_op_o   = 2'b10;
      pi1_addr_o = fetch_addr_q;
      pi1_sel_o  = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= pi1_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_en_q   <= 1'b0;
      fetch_addr_q <= '0;
      drain_addr_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hd_off_q     <= '0;
      instr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (redir_i) begin
        fetch_en_q   <= 1'b1;
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        count_q      <= '0;
        hd_off_q     <= redir_off;
        instr_addr_q <= redir_addr_i;
        if ((state_q != IDLE) && !pi1_rdy_i) drain_addr_q <= redir_word;
        else                                 fetch_addr_q <= redir_word;
      end else begin
        count_q <= count_nxt;
        if (push) begin
          wr_ptr_q     <= wr_ptr_q + PTRW'(1);
          fetch_addr_q <= fetch_addr_q + ADDRBITSZ'(1);
        end
        if (state_q == DRAIN && pi1_rdy_i) fetch_addr_q <= drain_addr_q;
        if (pop) begin
          instr_addr_q <= instr_addr_q + (ARCHBITSZ-1)'(1);
          hd_off_q     <= free ? '0 : hd_off_q + HWBITS'(1);
        end
        if (free) rd_ptr_q <= rd_ptr_q + PTRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pu_ifetch.sv
// Bench for pu_ifetch: directed scenarios then randomized traffic against a memory/stream model.
// Latency: expected stream is the linear halfword sequence from each redirect target.
// Backpressure: bus ready and consumer ready are randomized independently.
module tb_pu_ifetch;
  localparam int AW    = 32;
  localparam int ADDRW = 30;

  logic clk = 1'b0;
  logic rst_i, redir_i, pi1_rdy_i, instr_rdy_i;
  logic [AW-2:0]   redir_addr_i;
  logic [1:0]      pi1_op_o;
  logic [ADDRW-1:0] pi1_addr_o;
  logic [AW-1:0]   pi1_data_o, pi1_data_i;
  logic [AW/8-1:0] pi1_sel_o;
  logic [15:0]     instr_o;
  logic [AW-2:0]   instr_addr_o;
  logic            instr_vld_o, empty_o;

  pu_ifetch #(.ARCHBITSZ(AW), .BUFSZ(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .redir_i(redir_i), .redir_addr_i(redir_addr_i),
    .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o),
    .pi1_sel_o(pi1_sel_o), .pi1_data_i(pi1_data_i), .pi1_rdy_i(pi1_rdy_i),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_vld_o(instr_vld_o),
    .instr_rdy_i(instr_rdy_i), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] a;
    logic [15:0] d;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  int reads_done = 0;

  // Memory image: hashed per word address, with one fixed word for the offset test.
  function automatic logic [31:0] memf(input logic [29:0] w);
    logic [31:0] x;
    if (w == 30'h81) return 32'hAAAA5555;
    x = {2'b00, w} * 32'h9E3779B1;
    return x ^ (x >> 15);
  endfunction

  function automatic logic [15:0] hw(input logic [30:0] h);
    logic [31:0] w;
    w = memf(h[30:1]);
    return h[0] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; a redirect loads the expected halfword stream.
  task automatic cyc(input logic rd, input logic [30:0] ra, input logic ir,
                     input logic br, input logic rs);
    logic [29:0] a;
    @(posedge clk);
    #1;
    a = pi1_addr_o;
    pi1_data_i   = memf(a);
    rst_i        = rs;
    redir_i      = rd;
    redir_addr_i = ra;
    instr_rdy_i  = ir;
    pi1_rdy_i    = br;
    if (rs) sb_q.delete();
    else if (rd) begin
      sb_q.delete();
      for (int i = 0; i < 256; i++) begin
        exp_t e;
        e.a = ra + 31'(i);
        e.d = hw(e.a);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b0, 31'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 31'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: bus protocol, fetch address sequence and popped instructions.
  bit fetch_on = 0, stale_ok = 0, prev_pend = 0, prev_redir = 0;
  logic [29:0] exp_fetch = '0, stale_addr = '0, prev_addr = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_op", 64'(pi1_op_o), 64'h0);
      chk("rst_addr", 64'(pi1_addr_o), 64'h0);
      chk("rst_sel", 64'(pi1_sel_o), 64'h0);
      chk("rst_data", 64'(pi1_data_o), 64'h0);
      chk("rst_instr", 64'(instr_o), 64'h0);
      chk("rst_iaddr", 64'(instr_addr_o), 64'h0);
      chk("rst_vld", 64'(instr_vld_o), 64'h0);
      chk("rst_empty", 64'(empty_o), 64'h1);
      fetch_on = 0; stale_ok = 0; prev_pend = 0; prev_redir = 0;
    end else begin
      chk("sel", 64'(pi1_sel_o), (pi1_op_o == 2'b10) ? 64'hF : 64'h0);
      chk("data_o", 64'(pi1_data_o), 64'h0);
      if (!fetch_on) chk("op_before_redir", 64'(pi1_op_o), 64'h0);
      if (prev_pend) begin
        chk("op_hold", 64'(pi1_op_o), 64'h2);
        chk("addr_hold", 64'(pi1_addr_o), 64'(prev_addr));
      end
      if (pi1_op_o == 2'b10 && pi1_rdy_i) begin
        reads_done++;
        if (stale_ok) begin
          chk("stale_addr", 64'(pi1_addr_o), 64'(stale_addr));
          stale_ok = 0;
        end else begin
          chk("fetch_addr", 64'(pi1_addr_o), 64'(exp_fetch));
          exp_fetch = exp_fetch + 30'd1;
        end
      end
`ifndef PU_IFETCH_BYPASS_EN
      chk("vld_vs_empty", 64'(instr_vld_o), 64'(!empty_o));
      if (prev_redir) chk("vld_after_redir", 64'(instr_vld_o), 64'h0);
`endif
      if (instr_vld_o && instr_rdy_i && !redir_i) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop_unexpected: got instr_addr 0x%0h, expected no pop", instr_addr_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("instr_addr", 64'(instr_addr_o), 64'(e.a));
          chk("instr", 64'(instr_o), 64'(e.d));
        end
      end
      if (redir_i) begin
        stale_ok   = (pi1_op_o == 2'b10) && !pi1_rdy_i;
        stale_addr = pi1_addr_o;
        exp_fetch  = redir_addr_i[30:1];
        fetch_on   = 1;
      end
      prev_pend  = (pi1_op_o == 2'b10) && !pi1_rdy_i;
      prev_addr  = pi1_addr_o;
      prev_redir = redir_i;
    end
  end

  int base, since, bpct, ipct;

  initial begin
    rst_i = 1'b1; redir_i = 1'b0; redir_addr_i = '0; pi1_rdy_i = 1'b0;
    pi1_data_i = '0; instr_rdy_i = 1'b0;

    // Reset, then no fetching until a redirect.
    do_reset();
    repeat (4) begin
      cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
      chk("idle_op", 64'(pi1_op_o), 64'h0);
      chk("idle_empty", 64'(empty_o), 64'h1);
    end

    // Sequential fetch from 0x100.
    cyc(1'b1, 31'h100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
      chk("seq_op", 64'(pi1_op_o), 64'h2);
      chk("seq_addr", 64'(pi1_addr_o), 64'(30'h80 + 30'(i)));
    end
    repeat (10) cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0);

    // Start offset: 0x103 yields 0xAAAA first; 0x5555 is skipped.
    do_reset();
    cyc(1'b1, 31'h103, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
`ifdef PU_IFETCH_BYPASS_EN
    chk("off_instr", 64'(instr_o), 64'hAAAA);
    chk("off_iaddr", 64'(instr_addr_o), 64'h103);
`endif
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
`ifndef PU_IFETCH_BYPASS_EN
    chk("off_vld", 64'(instr_vld_o), 64'h1);
    chk("off_instr", 64'(instr_o), 64'hAAAA);
    chk("off_iaddr", 64'(instr_addr_o), 64'h103);
`endif
    repeat (6) cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0);

    // Full buffer: exactly four reads, then one more after a word is freed.
    do_reset();
    cyc(1'b1, 31'h100, 1'b0, 1'b0, 1'b0);
    base = reads_done;
    repeat (12) cyc(1'b0, 31'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("full_reads", 64'(reads_done - base), 64'd4);
    chk("full_op", 64'(pi1_op_o), 64'h0);
    repeat (2) cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0);
    repeat (10) cyc(1'b0, 31'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("refill_reads", 64'(reads_done - base), 64'd5);
    chk("refill_op", 64'(pi1_op_o), 64'h0);

    // Redirect during a pending read at 0x81: stale word dropped, next read at 0x100.
    do_reset();
    cyc(1'b1, 31'h100, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 31'h0, 1'b1, 1'b0, 1'b0); #1;
    chk("pend_addr", 64'(pi1_addr_o), 64'h81);
    cyc(1'b1, 31'h200, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
    chk("drain_addr", 64'(pi1_addr_o), 64'h81);
    chk("drain_vld", 64'(instr_vld_o), 64'h0);
    cyc(1'b0, 31'h0, 1'b1, 1'b0, 1'b0); #1;
    chk("post_drain_op", 64'(pi1_op_o), 64'h2);
    chk("post_drain_addr", 64'(pi1_addr_o), 64'h100);
    chk("post_drain_vld", 64'(instr_vld_o), 64'h0);
    repeat (8) cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a read; fetching stays off afterwards.
    cyc(1'b1, 31'h40, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 31'h0, 1'b0, 1'b0, 1'b1); #1;
    chk("midrst_op", 64'(pi1_op_o), 64'h0);
    chk("midrst_empty", 64'(empty_o), 64'h1);
    repeat (5) begin
      cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
      chk("postrst_op", 64'(pi1_op_o), 64'h0);
    end

    // Address wrap from 0x7FFFFFFF.
    cyc(1'b1, 31'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
`ifdef PU_IFETCH_BYPASS_EN
    chk("wrap_byp_vld", 64'(instr_vld_o), 64'h1);
    chk("wrap_byp_iaddr", 64'(instr_addr_o), 64'h7FFFFFFF);
`else
    chk("wrap_vld", 64'(instr_vld_o), 64'h0);
`endif
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
    chk("wrap_fetch", 64'(pi1_addr_o), 64'h0);
`ifndef PU_IFETCH_BYPASS_EN
    chk("wrap_iaddr_first", 64'(instr_addr_o), 64'h7FFFFFFF);
    cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0); #1;
    chk("wrap_iaddr_next", 64'(instr_addr_o), 64'h0);
`endif
    repeat (8) cyc(1'b0, 31'h0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    since = 0; bpct = 60; ipct = 70;
    for (int c = 0; c < 3000; c++) begin
      logic rs, rd, ir, br;
      logic [30:0] ra;
      rs = ($urandom_range(0, 399) == 0);
      rd = !rs && (since >= 150 || $urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       ra = 31'h7FFFFFFF - 31'($urandom_range(0, 6));
        1:       ra = 31'($urandom_range(0, 63));
        default: ra = 31'($urandom);
      endcase
      if (rd) begin
        bpct = $urandom_range(20, 100);
        ipct = $urandom_range(5, 100);
      end
      ir = ($urandom_range(1, 100) <= ipct);
      br = ($urandom_range(1, 100) <= bpct);
      cyc(rd, ra, ir, br, rs);
      since = (rd || rs) ? 0 : since + 1;
    end
    cyc(1'b0, 31'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pu_ifetch.md
PU_IFETCH -- requirements
Module: pu_ifetch

Interface
REQ-001 SHALL have parameter ARCHBITSZ, default 32, bus/word width; legal values are 32 and 64.
REQ-002 SHALL have parameter BUFSZ, default 4, prefetch buffer depth in words; must be a power of two and at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port redir_i, input, 1 bit: one-cycle redirect/flush request.
REQ-006 SHALL have port redir_addr_i, input, ARCHBITSZ-1 bits: new instruction address in 16-bit units.
REQ-007 SHALL have port pi1_op_o, output, 2 bits: bus op, 2'b00 noop or 2'b10 read.
REQ-008 SHALL have port pi1_addr_o, output, ADDRBITSZ bits: word address, where ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
REQ-009 SHALL have port pi1_data_o, output, ARCHBITSZ bits: held at 0.
REQ-010 SHALL have port pi1_sel_o, output, ARCHBITSZ/8 bits: all ones during a read, 0 otherwise.
REQ-011 SHALL have port pi1_data_i, input, ARCHBITSZ bits: read data.
REQ-012 SHALL have port pi1_rdy_i, input, 1 bit: completes the current op.
REQ-013 SHALL have port instr_o, output, 16 bits: head instruction.
REQ-014 SHALL have port instr_addr_o, output, ARCHBITSZ-1 bits: address of instr_o in 16-bit units.
REQ-015 SHALL have port instr_vld_o, output, 1 bit: instr_o is valid.
REQ-016 SHALL have port instr_rdy_i, input, 1 bit: consumer pops the head when instr_vld_o is also 1.
REQ-017 SHALL have port empty_o, output, 1 bit: buffer holds no words.

Function
REQ-018 SHALL implement states IDLE (op noop), REQ (read held) and DRAIN (stale read held).
REQ-019 SHALL hold the read op and its address stable until a cycle with pi1_rdy_i=1; pi1_data_i is valid in that cycle.
REQ-020 SHALL go IDLE->REQ when fetching is enabled and word count < BUFSZ; it stays in REQ on completion while space remains, else returns to IDLE.
REQ-021 SHALL, on redir_i in REQ without pi1_rdy_i that same cycle, enter DRAIN; in DRAIN it discards the returned word, then enters REQ at the new address.
REQ-022 SHALL, on redir_i, flush the buffer and set the fetch word address to redir_addr_i[ARCHBITSZ-2:clog2(ARCHBITSZ/16)]; the low bits give the start halfword offset.
REQ-023 SHALL give redir_i priority over a push or pop in the same cycle; instr_vld_o is 0 in the next cycle.
REQ-024 SHALL order halfwords little-endian: halfword k is pi1_data_i[16k+15:16k].
REQ-025 SHALL, after a redirect, skip halfwords below the start offset in the first word.
REQ-026 SHALL pop one halfword per cycle when instr_vld_o and instr_rdy_i are both 1, and free the word after its last halfword is popped.
REQ-027 SHALL allow a push and a pop in the same cycle with the word count unchanged, including when the buffer is full.
REQ-028 SHALL use pointers clog2(BUFSZ) bits wide and a count clog2(BUFSZ)+1 bits wide, all wrapping modulo.
REQ-029 SHALL increment instr_addr_o by 1 per pop, and the fetch address by 1 per accepted word, both modulo 2^width.
REQ-030 SHALL drive instr_vld_o=0 and empty_o=1 when the count is 0.

Reset
REQ-031 SHALL, while rst_i=1, drive pi1_op_o, pi1_addr_o, pi1_sel_o, pi1_data_o, instr_o, instr_addr_o and instr_vld_o to 0, and empty_o to 1.
REQ-032 SHALL, while rst_i=1, set state IDLE, clear pointers and count, and disable fetching; any in-flight read is abandoned.
REQ-033 SHALL resume fetching only at the first redir_i after reset.

Configuration
REQ-034 SHALL provide bypass when PU_IFETCH_BYPASS_EN is defined: with the buffer empty and a read completing, the addressed halfword appears on instr_o with instr_vld_o=1 in that same cycle.
REQ-035 SHALL, under bypass, push the word to the buffer with that halfword already popped if instr_rdy_i=1 that cycle.
REQ-036 SHALL, when PU_IFETCH_BYPASS_EN is undefined, deliver the first instruction at the earliest one cycle after its read completes.

Verification
REQ-037 SHALL be verified by: reset, then redir_i with addr 0x100, bus rdy each cycle -> pi1_addr_o 0x80, 0x81, ... (ARCHBITSZ=32); instr_addr_o 0x100, 0x101 in order.
REQ-038 SHALL be verified by: redir_i with addr 0x103, data 0xAAAA5555 -> first instr_o 0xAAAA with instr_addr_o 0x103; halfword 0x5555 is never output.
REQ-039 SHALL be verified by: instr_rdy_i=0 with BUFSZ=4 -> exactly 4 reads, then pi1_op_o 0; one pop of a full word's last halfword -> exactly one new read.
REQ-040 SHALL be verified by: redir_i to 0x200 during a pending read at 0x81 -> the 0x81 data is discarded, the next op is at 0x100, and no stale instruction is visible.
REQ-041 SHALL be verified by: rst_i asserted mid-read -> all outputs reset values next cycle, and pi1_op_o stays 0 until redir_i.
REQ-042 SHALL be verified by: redir_i with addr 0x7FFFFFFF -> fetch wraps to word 0 and instr_addr_o wraps to 0; with bypass enabled, first instr_vld_o occurs in the cycle of the first pi1_rdy_i.
